// File: rtl/seg_pkg.sv
// Shared types and segment patterns for the 7-segment scan driver.
// Pattern bit order: [6]=a ... [0]=g, active-high (1 = segment lit).
package seg_pkg;

    typedef logic [2:0] digit_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_BLANK = 7'b0000000;

    // Register width for a counter over 0..v-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/seg_digit_decode.sv
// Combinational 3-bit digit code to 7-segment pattern decoder with a blank
// override. Instantiated once on the currently scanned digit.
module seg_digit_decode
    import seg_pkg::*;
(
    input  digit_t i_code,
    input  logic   i_blank,
    output seg_t   o_seg
);

    // Look up the segment pattern; blank forces all segments off.
    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_code)
                3'd0:    o_seg = SEG_0;
                3'd1:    o_seg = SEG_1;
                3'd2:    o_seg = SEG_2;
                3'd3:    o_seg = SEG_3;
                3'd4:    o_seg = SEG_4;
                3'd5:    o_seg = SEG_5;
                3'd6:    o_seg = SEG_6;
                default: o_seg = SEG_7;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan driver for a NUM_DIGITS-digit 7-segment display.
// A prescaler divides each digit slot into DIV cycles, the first of which
// is a blanking cycle. Frames are double-buffered: a load lands in a
// pending buffer and is committed only at a frame boundary, so a displayed
// frame is never torn mid-scan.
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 is always shown).
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3*NUM_DIGITS-1:0] din,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_start,
    output logic                    upd_pending
);

    localparam int CW = clog2_min1(DIV);
    localparam int IW = clog2_min1(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           r_cnt;
    logic [IW-1:0]           r_idx;
    logic [3*NUM_DIGITS-1:0] r_disp;
    logic [3*NUM_DIGITS-1:0] r_pend;
    logic                    r_pnd;
    logic                    r_frame_start;

    logic   w_slot_end;
    logic   w_boundary;
    digit_t w_digits [NUM_DIGITS];
    digit_t w_code;
    logic   w_blank;
    seg_t   w_seg;

    assign w_slot_end = (r_cnt == CNT_LAST);
    assign w_boundary = w_slot_end && (r_idx == IDX_LAST);

    // Slot prescaler and scan index; the index wrap is the frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= w_boundary ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Frame double buffer: a load on the boundary bypasses the pending
    // buffer; otherwise the pending frame is committed at the boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp <= '0;
            r_pend <= '0;
            r_pnd  <= 1'b0;
        end else if (load && w_boundary) begin
            r_disp <= din;
            r_pnd  <= 1'b0;
        end else if (load) begin
            r_pend <= din;
            r_pnd  <= 1'b1;
        end else if (w_boundary && r_pnd) begin
            r_disp <= r_pend;
            r_pnd  <= 1'b0;
        end
    end

    // Registered start-of-frame pulse, high while idx==0 and cnt==0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_boundary;
        end
    end

    // Split the displayed frame into digits and drive one-hot enables,
    // suppressed during each slot's blanking cycle.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign w_digits[gi] = r_disp[3*gi +: 3];
        assign dig_en[gi]   = (r_cnt != '0) && (r_idx == IW'(gi));
    end

    // Select the code of the digit currently being scanned.
    always_comb begin
        w_code = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_code = w_digits[i];
            end
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // w_upper_zero[i]: digit i and every digit above it are code 0.
    logic [NUM_DIGITS:1] w_upper_zero;
    assign w_upper_zero[NUM_DIGITS] = 1'b1;
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
        assign w_upper_zero[gi] = (r_disp[3*gi +: 3] == 3'd0) && w_upper_zero[gi+1];
    end

    // Blank the scanned digit if it is a leading zero; digit 0 never blanks.
    always_comb begin
        w_blank = 1'b0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_blank = w_upper_zero[i];
            end
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    seg_digit_decode u_decode (
        .i_code  (w_code),
        .i_blank (w_blank),
        .o_seg   (w_seg)
    );

    assign seg         = w_seg;
    assign frame_start = r_frame_start;
    assign upd_pending = r_pnd;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (NUM_DIGITS=4, DIV=4).
// Reference model: time since reset plus the frame-level load/commit rules.
module tb_seg_scan_driver;

    localparam int N     = 4;
    localparam int DV    = 4;
    localparam int FRAME = N * DV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [11:0] din = '0;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        frame_start;
    logic        upd_pending;

    always #5 clk = ~clk;

    seg_scan_driver #(.NUM_DIGITS(N), .DIV(DV)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .load        (load),
        .seg         (seg),
        .dig_en      (dig_en),
        .frame_start (frame_start),
        .upd_pending (upd_pending)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: cycles since reset, shown frame, queued frame.
    int          m_t    = 0;
    logic [11:0] m_disp = '0;
    logic [11:0] m_pend = '0;
    logic        m_pnd  = 1'b0;
    logic        m_fs   = 1'b0;

    function automatic logic [6:0] pat(input int c);
        case (c)
            0:       return 7'b1111110;
            1:       return 7'b0110000;
            2:       return 7'b1101101;
            3:       return 7'b1111001;
            4:       return 7'b0110011;
            5:       return 7'b1011011;
            6:       return 7'b1011111;
            default: return 7'b1110000;
        endcase
    endfunction

    // Expected {seg, dig_en, frame_start, upd_pending} at the current cycle.
    function automatic logic [12:0] exp_word();
        int          cnt;
        int          idx;
        int          upper;
        logic [6:0]  s;
        logic [3:0]  de;
        cnt   = m_t % DV;
        idx   = (m_t / DV) % N;
        upper = int'(m_disp >> (3 * idx));
        s     = pat(upper & 7);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (idx > 0 && upper == 0) s = 7'b0000000;
`endif
        de = (cnt == 0) ? 4'b0000 : 4'(1 << idx);
        return {s, de, m_fs, m_pnd};
    endfunction

    // Apply inputs for one clock edge, then advance the model.
    task automatic step(input logic r, input logic l, input logic [11:0] d);
        logic bnd;
        rst = r; load = l; din = d;
        @(posedge clk);
        #1;
        if (r) begin
            m_t = 0; m_disp = '0; m_pend = '0; m_pnd = 1'b0; m_fs = 1'b0;
        end else begin
            bnd  = (m_t % FRAME) == FRAME - 1;
            m_fs = bnd;
            if (l && bnd) begin
                m_disp = d; m_pnd = 1'b0;
            end else if (l) begin
                m_pend = d; m_pnd = 1'b1;
            end else if (bnd && m_pnd) begin
                m_disp = m_pend; m_pnd = 1'b0;
            end
            m_t++;
        end
        rst = 1'b0; load = 1'b0;
    endtask

    // Idle until the frame phase (cycle within frame) equals ph.
    task automatic advance_to(input int ph);
        for (int k = 0; k < FRAME + 1 && (m_t % FRAME) != ph; k++) step(0, 0, '0);
    endtask

    task automatic test_reset();
        step(1, 0, '0);
        n_chk++; if (seg !== 7'b1111110) $display("FAIL reset_seg got=%b want=1111110", seg); else n_pass++;
        n_chk++; if (dig_en !== 4'b0000) $display("FAIL reset_dig_en got=%b want=0000", dig_en); else n_pass++;
        n_chk++; if (frame_start !== 1'b0) $display("FAIL reset_frame_start got=%b want=0", frame_start); else n_pass++;
        n_chk++; if (upd_pending !== 1'b0) $display("FAIL reset_upd_pending got=%b want=0", upd_pending); else n_pass++;
    endtask

    task automatic test_scan_no_load();
        int first_fs = -1;
        for (int k = 1; k <= 40; k++) begin
            step(0, 0, '0);
            if (frame_start === 1'b1 && first_fs < 0) first_fs = k;
            n_chk++;
            if ({seg, dig_en, frame_start, upd_pending} !== exp_word())
                $display("FAIL scan t=%0d got=%b want=%b", m_t, {seg, dig_en, frame_start, upd_pending}, exp_word());
            else n_pass++;
        end
        n_chk++; if (first_fs !== 16) $display("FAIL first_frame_start got=%0d want=16", first_fs); else n_pass++;
    endtask

    task automatic test_load_midframe();
        logic [6:0] want [4];
        want[0] = 7'b0110000; want[1] = 7'b1111001; want[2] = 7'b1011011; want[3] = 7'b1110000;
        advance_to(5);
        step(0, 1, 12'o7531);
        n_chk++; if (upd_pending !== 1'b1) $display("FAIL load_pending got=%b want=1", upd_pending); else n_pass++;
        advance_to(0);
        n_chk++; if (upd_pending !== 1'b0) $display("FAIL commit_clears_pending got=%b want=0", upd_pending); else n_pass++;
        for (int i = 0; i < N; i++) begin
            advance_to(4 * i + 1);
            n_chk++;
            if (seg !== want[i]) $display("FAIL load_digit%0d got=%b want=%b", i, seg, want[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back_load();
        logic saw_one = 1'b0;
        logic saw_two = 1'b0;
        advance_to(2);
        step(0, 1, 12'o1111);
        advance_to(6);
        step(0, 1, 12'o2222);
        advance_to(0);
        for (int k = 0; k < 2 * FRAME; k++) begin
            step(0, 0, '0);
            if (dig_en != 4'b0000 && seg === 7'b0110000) saw_one = 1'b1;
            if (dig_en != 4'b0000 && seg === 7'b1101101) saw_two = 1'b1;
            n_chk++;
            if ({seg, dig_en, frame_start, upd_pending} !== exp_word())
                $display("FAIL b2b t=%0d got=%b want=%b", m_t, {seg, dig_en, frame_start, upd_pending}, exp_word());
            else n_pass++;
        end
        n_chk++; if (saw_one !== 1'b0) $display("FAIL b2b_no_one got=%b want=0", saw_one); else n_pass++;
        n_chk++; if (saw_two !== 1'b1) $display("FAIL b2b_saw_two got=%b want=1", saw_two); else n_pass++;
    endtask

    task automatic test_boundary_load();
        logic [11:0] d;
        d = 12'($urandom);
        advance_to(FRAME - 1);
        step(0, 1, d);
        n_chk++; if (upd_pending !== 1'b0) $display("FAIL bnd_pending got=%b want=0", upd_pending); else n_pass++;
        n_chk++; if (seg !== pat(int'(d[2:0]))) $display("FAIL bnd_digit0 got=%b want=%b", seg, pat(int'(d[2:0]))); else n_pass++;
        n_chk++; if (frame_start !== 1'b1) $display("FAIL bnd_frame_start got=%b want=1", frame_start); else n_pass++;
        for (int k = 0; k < FRAME; k++) begin
            step(0, 0, '0);
            n_chk++;
            if ({seg, dig_en, frame_start, upd_pending} !== exp_word())
                $display("FAIL bnd t=%0d got=%b want=%b", m_t, {seg, dig_en, frame_start, upd_pending}, exp_word());
            else n_pass++;
        end
    endtask

    task automatic test_reset_midframe();
        advance_to(6);
        step(0, 1, 12'($urandom) | 12'o4000);
        step(0, 0, '0);
        step(1, 0, '0);
        n_chk++;
        if ({seg, dig_en, frame_start, upd_pending} !== {7'b1111110, 4'b0000, 1'b0, 1'b0})
            $display("FAIL midreset got=%b want=%b", {seg, dig_en, frame_start, upd_pending}, {7'b1111110, 4'b0000, 1'b0, 1'b0});
        else n_pass++;
        for (int k = 0; k < 2 * FRAME; k++) begin
            step(0, 0, '0);
            n_chk++;
            if ({seg, dig_en, frame_start, upd_pending} !== exp_word())
                $display("FAIL midreset t=%0d got=%b want=%b", m_t, {seg, dig_en, frame_start, upd_pending}, exp_word());
            else n_pass++;
        end
    endtask

    task automatic test_leading_zero();
`ifdef SEG_LEADING_ZERO_BLANK_EN
        logic [6:0]  want [4];
        logic [11:0] frames [2];
        frames[0] = 12'o0030;
        frames[1] = 12'o0000;
        for (int f = 0; f < 2; f++) begin
            want[0] = 7'b1111110;
            want[1] = (f == 0) ? 7'b1111001 : 7'b0000000;
            want[2] = 7'b0000000;
            want[3] = 7'b0000000;
            advance_to(FRAME - 1);
            step(0, 1, frames[f]);
            for (int i = 0; i < N; i++) begin
                advance_to(4 * i + 1);
                n_chk++;
                if (seg !== want[i]) $display("FAIL lz%0d_digit%0d got=%b want=%b", f, i, seg, want[i]);
                else n_pass++;
            end
        end
`endif
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            step(0, ($urandom_range(7) == 0), 12'($urandom));
            n_chk++;
            if ({seg, dig_en, frame_start, upd_pending} !== exp_word())
                $display("FAIL random t=%0d got=%b want=%b", m_t, {seg, dig_en, frame_start, upd_pending}, exp_word());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_scan_no_load();
        test_load_midframe();
        test_back_to_back_load();
        test_boundary_load();
        test_reset_midframe();
        test_leading_zero();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
